dmem_write_arbiter: RTL

DMEM_WRITE_ARBITER -- requirements
Module: dmem_write_arbiter

---
 rtl/dmem_write_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dmem_write_arbiter.sv
// Single-write-port data memory arbiter for a dual-issue memory stage.
// Serializes two stores to different words over two cycles (stalling M),
// merges same-word stores (younger lane wins) and forwards lane-1 store
// data to a same-word lane-2 load.
module dmem_write_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite_M,
    input  logic             MemWrite_M2,
    input  logic             MemRead_M2,
    input  logic [31:0]      ALUOut_M,
    input  logic [31:0]      ALUOut_M2,
    input  logic [31:0]      WriteData_M,
    input  logic [31:0]      WriteData_M2,
    input  logic [31:0]      RamRead2,
    output logic             WE_P,
    output logic [29:0]      WA_P,
    output logic [31:0]      WD_P,
    output logic [31:0]      ReadData_M2,
    output logic             Stall_M,
    output logic [CNT_W-1:0] ConflictCnt
);

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     lat_addr_q;
    logic [DW-1:0]     lat_data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              lat_en;

    logic [AW-1:0]     wa1;
    logic [AW-1:0]     wa2;
    logic              same_word;

    assign wa1       = ALUOut_M[31:2];
    assign wa2       = ALUOut_M2[31:2];
    assign same_word = (wa1 == wa2);

    // Byte-offset bits do not participate in word arbitration.
    logic unused_byte_bits;
    assign unused_byte_bits = &{1'b0, ALUOut_M[1:0], ALUOut_M2[1:0]};

    // Lane-2 load sees a same-word lane-1 store before it reaches the RAM.
    assign ReadData_M2 = (MemWrite_M && MemRead_M2 && same_word) ? WriteData_M : RamRead2;

    assign ConflictCnt = cnt_q;

    // State, latched lane-2 write and saturating conflict counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if (lat_en) begin
                lat_addr_q <= wa2;
                lat_data_q <= WriteData_M2;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Next state and write-port / stall selection; everything idle in reset.
    always_comb begin
        state_d = state_q;
        WE_P    = 1'b0;
        WA_P    = '0;
        WD_P    = '0;
        Stall_M = 1'b0;
        lat_en  = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (MemWrite_M && MemWrite_M2) begin
                        WE_P = 1'b1;
                        if (same_word) begin
                            WA_P = wa2;
                            WD_P = WriteData_M2;
                        end else begin
                            WA_P    = wa1;
                            WD_P    = WriteData_M;
                            Stall_M = 1'b1;
                            lat_en  = 1'b1;
                            state_d = SECOND;
                        end
                    end else if (MemWrite_M) begin
                        WE_P = 1'b1;
                        WA_P = wa1;
                        WD_P = WriteData_M;
                    end else if (MemWrite_M2) begin
                        WE_P = 1'b1;
                        WA_P = wa2;
                        WD_P = WriteData_M2;
                    end
                end
                SECOND: begin
                    WE_P    = 1'b1;
                    WA_P    = lat_addr_q;
                    WD_P    = lat_data_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
